noise_ram_read_scheduler: RTL and testbench



---
 rtl/noise_ram_read_scheduler_pkg.sv | 21 ++
 rtl/noise_ram_read_scheduler_if.sv | 37 +++
 rtl/noise_ram_read_scheduler_valid_pipe.sv | 41 ++++
 rtl/noise_ram_read_scheduler.sv | 155 +++++++++++++++
 tb/tb_noise_ram_read_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/noise_ram_read_scheduler_pkg.sv
// Shared types and default sizes for the channel-sample RAM read scheduler.
// Imported by the scheduler, its valid pipe and its bus interface.
package noise_ram_read_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    OWN_DEMOD = 1'b0,
    OWN_SIGMA = 1'b1
  } owner_e;

  localparam int CODE_LEN    = 256;
  localparam int FRAMES      = 16;
  localparam int DATA_WIDTH  = 15;
  localparam int RAM_LATENCY = 2;

endpackage

// File: rtl/noise_ram_read_scheduler_if.sv
// Reader handshakes and RAM port control of the read scheduler, plus FSM state for debug.
interface noise_ram_read_scheduler_if #(
  parameter int AW = 12
);
  import noise_ram_read_scheduler_pkg::*;

  // Requests are levels sampled only while the scheduler is idle; the granted reader gets a
  // one-cycle *_receive pulse, then valid_a/valid_b strobes mark RAM data meant for it alone.
  logic          demodulation_read_RAM;
  logic          RAM_read_receive;
  logic          demodulation_valid_a;
  logic          demodulation_valid_b;
  logic          sigma_read_RAM;
  logic          sigma_read_receive;
  logic          sigma_valid_a;
  logic          sigma_valid_b;
  logic          ena;
  logic          enb;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  state_e        state_dbg;

  modport master (
    input  demodulation_read_RAM, sigma_read_RAM,
    output RAM_read_receive, demodulation_valid_a, demodulation_valid_b,
    output sigma_read_receive, sigma_valid_a, sigma_valid_b,
    output ena, enb, addra, addrb, state_dbg
  );

  modport slave (
    output demodulation_read_RAM, sigma_read_RAM,
    input  RAM_read_receive, demodulation_valid_a, demodulation_valid_b,
    input  sigma_read_receive, sigma_valid_a, sigma_valid_b,
    input  ena, enb, addra, addrb, state_dbg
  );

endinterface

// File: rtl/noise_ram_read_scheduler_valid_pipe.sv
// RAM_Latency-deep delay line of {ena, enb}; its tap is steered to the current owner's valids.
module noise_ram_valid_pipe
  import noise_ram_read_scheduler_pkg::*;
#(
  parameter int RAM_Latency = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  logic   enb,
  input  owner_e owner,
  output logic   demod_valid_a,
  output logic   demod_valid_b,
  output logic   sigma_valid_a,
  output logic   sigma_valid_b
);

  logic [1:0] pipe_q [RAM_Latency];
  logic [1:0] pipe_d [RAM_Latency];

  always_comb begin
    pipe_d[0] = {ena, enb};
    for (int i = 1; i < RAM_Latency; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_Latency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    demod_valid_a = (owner == OWN_DEMOD) && pipe_q[RAM_Latency-1][1];
    demod_valid_b = (owner == OWN_DEMOD) && pipe_q[RAM_Latency-1][0];
    sigma_valid_a = (owner == OWN_SIGMA) && pipe_q[RAM_Latency-1][1];
    sigma_valid_b = (owner == OWN_SIGMA) && pipe_q[RAM_Latency-1][0];
  end

endmodule

// File: rtl/noise_ram_read_scheduler.sv
// Arbitrates the demodulator and sigma estimator onto the dual-port sample RAM and sweeps
// one frame per grant (even words on port a, odd on port b) with a wrapping frame pointer.
module noise_ram_read_scheduler
  import noise_ram_read_scheduler_pkg::*;
#(
  parameter int CodeLen      = CODE_LEN,
  parameter int CodeLen_bits = 8,
  parameter int Frames       = FRAMES,
  parameter int Frame_bits   = 4,
  parameter int RAM_Latency  = RAM_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  noise_ram_read_scheduler_if.master  bus,
  output logic [Frame_bits-1:0]       frame_ptr,
  output logic                        busy
);

  localparam int                    AW         = CodeLen_bits + Frame_bits;
  localparam int                    KW         = CodeLen_bits - 1;
  localparam logic [KW-1:0]         K_LAST     = KW'(CodeLen / 2 - 1);
  localparam logic [2:0]            DRAIN_LAST = 3'(RAM_Latency);
  localparam logic [Frame_bits-1:0] FRAME_LAST = Frame_bits'(Frames - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [KW-1:0]         k_q, k_d;
  logic [2:0]            drain_q, drain_d;
  logic [Frame_bits-1:0] frame_ptr_q, frame_ptr_d;
  logic                  ack_demod_q, ack_demod_d;
  logic                  ack_sigma_q, ack_sigma_d;
  logic                  en_q, en_d;
  logic [AW-1:0]         addra_q, addra_d;
  logic [AW-1:0]         addrb_q, addrb_d;

  logic                  grant_any;
  owner_e                grant_owner;
  logic [Frame_bits-1:0] frame_sel;

  // owner_q doubles as the last-grant record; resetting it to sigma lets the demodulator win the first tie.
  always_comb begin
    grant_any   = bus.demodulation_read_RAM || bus.sigma_read_RAM;
    grant_owner = OWN_DEMOD;
    if (bus.demodulation_read_RAM && bus.sigma_read_RAM)
      grant_owner = (owner_q == OWN_DEMOD) ? OWN_SIGMA : OWN_DEMOD;
    else if (bus.sigma_read_RAM)
      grant_owner = OWN_SIGMA;
  end

  // Sigma reads the frame the demodulator consumed most recently.
  always_comb begin
    frame_sel = frame_ptr_q;
    if (owner_q == OWN_SIGMA)
      frame_sel = (frame_ptr_q == '0) ? FRAME_LAST : frame_ptr_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any) state_d = S_ISSUE;
      S_ISSUE: if (k_q == K_LAST) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM controls are registered, so each output phase trails its state by one cycle;
  // DRAIN therefore spans RAM_Latency+1 states to give RAM_Latency disabled output cycles.
  always_comb begin
    owner_d     = owner_q;
    k_d         = k_q;
    drain_d     = drain_q;
    frame_ptr_d = frame_ptr_q;
    ack_demod_d = 1'b0;
    ack_sigma_d = 1'b0;
    en_d        = 1'b0;
    addra_d     = '0;
    addrb_d     = '0;
    case (state_q)
      S_IDLE: begin
        k_d     = '0;
        drain_d = '0;
        if (grant_any) begin
          owner_d     = grant_owner;
          ack_demod_d = (grant_owner == OWN_DEMOD);
          ack_sigma_d = (grant_owner == OWN_SIGMA);
        end
      end
      S_ISSUE: begin
        en_d    = 1'b1;
        addra_d = {frame_sel, k_q, 1'b0};
        addrb_d = {frame_sel, k_q, 1'b1};
        k_d     = k_q + KW'(1);
      end
      S_DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == DRAIN_LAST && owner_q == OWN_DEMOD)
          frame_ptr_d = (frame_ptr_q == FRAME_LAST) ? '0 : frame_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_SIGMA;
      k_q         <= '0;
      drain_q     <= '0;
      frame_ptr_q <= '0;
      ack_demod_q <= 1'b0;
      ack_sigma_q <= 1'b0;
      en_q        <= 1'b0;
      addra_q     <= '0;
      addrb_q     <= '0;
    end else begin
      owner_q     <= owner_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      frame_ptr_q <= frame_ptr_d;
      ack_demod_q <= ack_demod_d;
      ack_sigma_q <= ack_sigma_d;
      en_q        <= en_d;
      addra_q     <= addra_d;
      addrb_q     <= addrb_d;
    end
  end

  noise_ram_valid_pipe #(.RAM_Latency(RAM_Latency)) u_valid_pipe (
    .clk           (clk),
    .rst           (rst),
    .ena           (en_q),
    .enb           (en_q),
    .owner         (owner_q),
    .demod_valid_a (bus.demodulation_valid_a),
    .demod_valid_b (bus.demodulation_valid_b),
    .sigma_valid_a (bus.sigma_valid_a),
    .sigma_valid_b (bus.sigma_valid_b)
  );

  assign bus.RAM_read_receive   = ack_demod_q;
  assign bus.sigma_read_receive = ack_sigma_q;
  assign bus.ena                = en_q;
  assign bus.enb                = en_q;
  assign bus.addra              = addra_q;
  assign bus.addrb              = addrb_q;
  assign bus.state_dbg          = state_q;
  assign frame_ptr              = frame_ptr_q;
  assign busy                   = (state_q != S_IDLE);

endmodule

// File: tb/tb_noise_ram_read_scheduler.sv
// Bench for noise_ram_read_scheduler: grant table, frame wrap, mid-sweep sigma request and
// mid-sweep reset, with an address scoreboard fed at grant time.
module tb_noise_ram_read_scheduler;
  import noise_ram_read_scheduler_pkg::*;

  localparam int CL   = 256;
  localparam int CLB  = 8;
  localparam int FR   = 16;
  localparam int FRB  = 4;
  localparam int LAT  = 2;
  localparam int AW   = CLB + FRB;
  localparam int HALF = CL / 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [FRB-1:0] frame_ptr;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [2*AW-1:0] exp_q[$];
  logic [2*AW-1:0] mon_e;

  typedef struct {
    logic   dreq;
    logic   sreq;
    owner_e owner;
    int     frame;
    int     fp_after;
    int     sig_at;
  } vec_t;
  vec_t vecs[9];

  noise_ram_read_scheduler_if #(.AW(AW)) bus ();

  noise_ram_read_scheduler #(
    .CodeLen(CL), .CodeLen_bits(CLB), .Frames(FR), .Frame_bits(FRB), .RAM_Latency(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_ptr (frame_ptr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Address scoreboard: every enabled RAM cycle consumes one expected {addra, addrb}.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.ena || bus.enb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_enable", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("ena_enb_pair", {bus.ena, bus.enb}, 2'b11);
          check("addra", bus.addra, mon_e[2*AW-1:AW]);
          check("addrb", bus.addrb, mon_e[AW-1:0]);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {bus.addra, bus.addrb}, 0);
    check({tag, "_ctrl"}, {bus.RAM_read_receive, bus.sigma_read_receive,
                           bus.demodulation_valid_a, bus.demodulation_valid_b,
                           bus.sigma_valid_a, bus.sigma_valid_b,
                           bus.ena, bus.enb, frame_ptr, busy}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.demodulation_read_RAM = 1'b0;
    bus.sigma_read_RAM = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", bus.state_dbg, S_IDLE);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_frame(input int frame);
    for (int k = 0; k < HALF; k++)
      exp_q.push_back({AW'(frame * CL + 2 * k), AW'(frame * CL + 2 * k + 1)});
  endtask

  task automatic do_sweep(input logic dreq, input logic sreq, input owner_e exp_owner,
                          input int exp_frame, input int exp_fp_after, input int sig_at);
    int   cyc, ack_wait, first_en, first_v, last_v, va, vb, other_v, extra_ack, done_cyc;
    logic got_ack, own_a, own_b, oth_a, oth_b;
    @(negedge clk);
    bus.demodulation_read_RAM = dreq;
    bus.sigma_read_RAM = sreq;
    got_ack = 1'b0;
    ack_wait = -1;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(posedge clk); #1;
      if (bus.RAM_read_receive || bus.sigma_read_receive) begin
        got_ack = 1'b1;
        ack_wait = i;
      end
    end
    check("ack_seen", got_ack, 1);
    check("ack_latency", ack_wait, 0);
    check("ack_demod", bus.RAM_read_receive, exp_owner == OWN_DEMOD);
    check("ack_sigma", bus.sigma_read_receive, exp_owner == OWN_SIGMA);
    bus.demodulation_read_RAM = 1'b0;
    bus.sigma_read_RAM = 1'b0;
    if (!got_ack) return;
    push_frame(exp_frame);
    first_en = -1; first_v = -1; last_v = -1;
    va = 0; vb = 0; other_v = 0; extra_ack = 0; done_cyc = -1;
    for (cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (sig_at != 0 && cyc == sig_at) bus.sigma_read_RAM = 1'b1;
      if (bus.ena && first_en < 0) first_en = cyc;
      own_a = (exp_owner == OWN_DEMOD) ? bus.demodulation_valid_a : bus.sigma_valid_a;
      own_b = (exp_owner == OWN_DEMOD) ? bus.demodulation_valid_b : bus.sigma_valid_b;
      oth_a = (exp_owner == OWN_DEMOD) ? bus.sigma_valid_a : bus.demodulation_valid_a;
      oth_b = (exp_owner == OWN_DEMOD) ? bus.sigma_valid_b : bus.demodulation_valid_b;
      if (own_a) begin
        va++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (own_b) vb++;
      if (oth_a || oth_b) other_v++;
      if (bus.RAM_read_receive || bus.sigma_read_receive) extra_ack++;
      if (!busy) done_cyc = cyc;
    end
    check("sweep_done", done_cyc >= 0, 1);
    check("first_en_cycle", first_en, 1);
    check("valid_a_count", va, HALF);
    check("valid_b_count", vb, HALF);
    check("first_valid_latency", first_v - first_en, LAT);
    check("valid_contiguous", last_v - first_v, HALF - 1);
    check("other_valid", other_v, 0);
    check("extra_ack", extra_ack, 0);
    check("idle_return_cycle", done_cyc, HALF + LAT + 1);
    check("frame_ptr_after", frame_ptr, exp_fp_after);
  endtask

  task automatic reset_mid_sweep();
    int stray;
    logic got_ack;
    @(negedge clk);
    bus.demodulation_read_RAM = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(posedge clk); #1;
      got_ack = bus.RAM_read_receive;
    end
    check("midrst_ack", got_ack, 1);
    bus.demodulation_read_RAM = 1'b0;
    push_frame(0);
    repeat (61) begin
      @(posedge clk); #1;
    end
    check("midrst_k60_addra", bus.addra, 120);
    check("midrst_valid_live", bus.demodulation_valid_a, 1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst_async");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (bus.ena || bus.enb || busy || bus.demodulation_valid_a || bus.demodulation_valid_b ||
          bus.sigma_valid_a || bus.sigma_valid_b) stray++;
    end
    check("midrst_no_activity", stray, 0);
    check("midrst_frame_ptr", frame_ptr, 0);
  endtask

  initial begin
    bus.demodulation_read_RAM = 1'b0;
    bus.sigma_read_RAM = 1'b0;

    vecs[0] = '{1'b0, 1'b1, OWN_SIGMA, 15, 0, 0};
    vecs[1] = '{1'b1, 1'b1, OWN_DEMOD,  0, 1, 0};
    vecs[2] = '{1'b1, 1'b1, OWN_SIGMA,  0, 1, 0};
    vecs[3] = '{1'b1, 1'b1, OWN_DEMOD,  1, 2, 0};
    vecs[4] = '{1'b1, 1'b1, OWN_SIGMA,  1, 2, 0};
    vecs[5] = '{1'b1, 1'b0, OWN_DEMOD,  2, 3, 0};
    vecs[6] = '{1'b1, 1'b0, OWN_DEMOD,  3, 4, 50};
    vecs[7] = '{1'b0, 1'b1, OWN_SIGMA,  3, 4, 0};
    vecs[8] = '{1'b1, 1'b1, OWN_DEMOD,  4, 5, 0};

    do_reset();
    for (int v = 0; v < 9; v++)
      do_sweep(vecs[v].dreq, vecs[v].sreq, vecs[v].owner, vecs[v].frame,
               vecs[v].fp_after, vecs[v].sig_at);

    do_reset();
    for (int f = 0; f < FR; f++)
      do_sweep(1'b1, 1'b0, OWN_DEMOD, f, (f + 1) % FR, 0);
    do_sweep(1'b1, 1'b0, OWN_DEMOD, 0, 1, 0);

    do_reset();
    reset_mid_sweep();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
